// File: rtl/sha_mem_responder.sv
// sha_mem_responder
// Word-addressed memory behind the SHA-256 core's memory-master port.
// It holds message input and hash output words. Core reads have a fixed
// one-cycle latency. A host port loads messages and reads results while the
// core is idle. A capture tracker reports when every word of the hash output
// window has been written by the core.
//
// Ports:
//   clk, reset_n        clock; asynchronous active-low reset
//   mem_we, mem_addr,   core port. It is serviced every cycle and always
//   mem_write_data,     wins over the host.
//   mem_read_data       registered core read data, valid one cycle after the address
//   core_active         high while the core owns the memory
//   host_req, host_we,  host request. It is held until host_ack.
//   host_addr, host_wdata
//   host_rdata,         host read data, valid while host_ack is high
//   host_ack            one-cycle completion pulse
//   out_base            first word address of the hash output window
//   arm                 one-cycle pulse that clears capture state and oob_err
//   wr_count            number of distinct window words written since arm
//   hash_valid          every window word has been written since arm
//   oob_err             sticky flag for an access outside 0..DEPTH-1
//   host_state          debug view of the host FSM state
//
// Host handshake: the host raises host_req with host_we, host_addr and
// host_wdata stable, and holds them until it sees host_ack. The access takes
// effect on the first edge in IDLE with core_active low. host_ack is then high
// for exactly one cycle. The FSM always returns to IDLE for one cycle before it
// accepts another request.
module sha_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          OUT_WORDS = 8,
  parameter logic [31:0] OOB_DATA  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  input  logic        core_active,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_ack,
  input  logic [15:0] out_base,
  input  logic        arm,
  output logic [3:0]  wr_count,
  output logic        hash_valid,
  output logic        oob_err,
  output logic [0:0]  host_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [31:0]          ram [DEPTH];
  logic [0:0]           state;
  logic [OUT_WORDS-1:0] mask;
  logic [OUT_WORDS-1:0] mask_set;
  logic [OUT_WORDS-1:0] mask_next;
  logic [3:0]           count_next;
  logic                 core_in_range;
  logic                 host_in_range;
  logic                 host_go;
  logic                 win_hit;
  logic [16:0]          win_lo;
  logic [16:0]          win_hi;
  logic [16:0]          core_addr17;
  logic [15:0]          win_offset;
  logic                 hv_next;
  logic                 oob_next;

  assign core_in_range = ({16'd0, mem_addr} < 32'(DEPTH));
  assign host_in_range = ({16'd0, host_addr} < 32'(DEPTH));
  assign host_go       = (state == ST_IDLE) && host_req && !core_active;
  assign host_ack      = (state == ST_ACK);
  assign host_state    = state;

  // Compare the window in 17 bits so that out_base + OUT_WORDS cannot wrap.
  assign core_addr17 = {1'b0, mem_addr};
  assign win_lo      = {1'b0, out_base};
  assign win_hi      = win_lo + 17'(OUT_WORDS);
  assign win_hit     = mem_we && (core_addr17 >= win_lo) && (core_addr17 < win_hi);
  assign win_offset  = mem_addr - out_base;

  always_comb begin
    mask_set = '0;
    for (int i = 0; i < OUT_WORDS; i++) begin
      mask_set[i] = win_hit && (win_offset == 16'(i));
    end
  end

  // arm clears the mask before a same-cycle window write lands in it.
  assign mask_next = (arm ? '0 : mask) | mask_set;

  always_comb begin
    count_next = '0;
    for (int i = 0; i < OUT_WORDS; i++) begin
      count_next = count_next + 4'(mask_next[i]);
    end
  end

  assign hv_next  = (arm ? 1'b0 : hash_valid) | (&mask_next);
  assign oob_next = (arm ? 1'b0 : oob_err) | !core_in_range | (host_go && !host_in_range);

  // Storage is not reset. The core write comes last, so it wins a same-address
  // collision with the host.
  always_ff @(posedge clk) begin
    if (host_go && host_we && host_in_range) begin
      ram[host_addr[AW-1:0]] <= host_wdata;
    end
    if (mem_we && core_in_range) begin
      ram[mem_addr[AW-1:0]] <= mem_write_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      mem_read_data <= '0;
      host_rdata    <= '0;
      mask          <= '0;
      wr_count      <= '0;
      hash_valid    <= 1'b0;
      oob_err       <= 1'b0;
    end else begin
      // Both reads sample the array before this edge's writes (read-before-write).
      mem_read_data <= core_in_range ? ram[mem_addr[AW-1:0]] : OOB_DATA;
      if (host_go && !host_we) begin
        host_rdata <= host_in_range ? ram[host_addr[AW-1:0]] : OOB_DATA;
      end
      case (state)
        ST_IDLE: state <= host_go ? ST_ACK : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      mask       <= mask_next;
      wr_count   <= count_next;
      hash_valid <= hv_next;
      oob_err    <= oob_next;
    end
  end

endmodule

// File: tb/tb_sha_mem_responder.sv
module tb_sha_mem_responder;

  localparam int          DEPTH     = 1024;
  localparam int          OUT_WORDS = 8;
  localparam logic [31:0] OOB_DATA  = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        core_active;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_ack;
  logic [15:0] out_base;
  logic        arm;
  logic [3:0]  wr_count;
  logic        hash_valid;
  logic        oob_err;
  logic [0:0]  host_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain array of words plus the set of captured window offsets.
  logic [31:0] model_mem [DEPTH];
  bit          model_flag [OUT_WORDS];
  bit          model_hv;
  bit          model_oob;
  int          model_base;
  logic [31:0] exp_q [$];

  sha_mem_responder #(.DEPTH(DEPTH), .OUT_WORDS(OUT_WORDS), .OOB_DATA(OOB_DATA)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .core_active(core_active),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .out_base(out_base), .arm(arm), .wr_count(wr_count),
    .hash_valid(hash_valid), .oob_err(oob_err), .host_state(host_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < OUT_WORDS; i++) c += model_flag[i] ? 1 : 0;
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < OUT_WORDS; i++) model_flag[i] = 1'b0;
    model_hv  = 1'b0;
    model_oob = 1'b0;
  endtask

  task automatic model_core(input bit we, input int addr, input logic [31:0] data,
                            input bit arm_in, output logic [31:0] rd);
    rd = (addr < DEPTH) ? model_mem[addr] : OOB_DATA;
    if (arm_in) model_clear();
    if (we && addr >= model_base && addr < model_base + OUT_WORDS)
      model_flag[addr - model_base] = 1'b1;
    if (model_count() == OUT_WORDS) model_hv = 1'b1;
    if (addr >= DEPTH) model_oob = 1'b1;
    if (we && addr < DEPTH) model_mem[addr] = data;
  endtask

  // ---------------- drivers ----------------
  // Called just after a falling edge; returns one falling edge later.
  task automatic core_cycle(input bit we, input int addr, input logic [31:0] data,
                            input bit arm_in, output logic [31:0] rd);
    mem_we         = we;
    mem_addr       = 16'(addr);
    mem_write_data = data;
    arm            = arm_in;
    model_core(we, addr, data, arm_in, rd);
    @(negedge clk);
  endtask

  task automatic core_idle();
    mem_we         = 1'b0;
    mem_addr       = 16'd0;
    mem_write_data = 32'd0;
    arm            = 1'b0;
  endtask

  // latency = falling edges until host_ack is seen, or -1 if the budget expires.
  task automatic host_access(input bit we, input int addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output int latency);
    int n = 0;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = 16'(addr);
    host_wdata = wdata;
    do begin
      @(negedge clk);
      n++;
    end while (!host_ack && n < 20);
    latency  = host_ack ? n : -1;
    rdata    = host_rdata;
    host_req = 1'b0;
    if (host_ack) begin
      if (we && addr < DEPTH) model_mem[addr] = wdata;
      if (addr >= DEPTH) model_oob = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    n_checks += 6;
    if (mem_read_data !== 32'd0) begin n_fail++; $display("FAIL reset_mem_read_data got=%h exp=0", mem_read_data); end
    if (host_rdata !== 32'd0)    begin n_fail++; $display("FAIL reset_host_rdata got=%h exp=0", host_rdata); end
    if (host_ack !== 1'b0)       begin n_fail++; $display("FAIL reset_host_ack got=%b exp=0", host_ack); end
    if (wr_count !== 4'd0)       begin n_fail++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
    if (hash_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_hash_valid got=%b exp=0", hash_valid); end
    if (oob_err !== 1'b0)        begin n_fail++; $display("FAIL reset_oob_err got=%b exp=0", oob_err); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic preload_all();
    logic [31:0] rd;
    core_active = 1'b1;
    for (int a = 0; a < DEPTH; a++) core_cycle(1'b1, a, $urandom, 1'b0, rd);
    core_idle();
    @(negedge clk);
  endtask

  task automatic test_host_rw();
    logic [31:0] rd;
    int lat;
    core_active = 1'b0;
    host_access(1'b1, 0, 32'h6162_6364, rd, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL host_write_latency got=%0d exp=1", lat); end
    @(negedge clk);
    host_access(1'b0, 0, 32'd0, rd, lat);
    n_checks += 2;
    if (lat !== 1) begin n_fail++; $display("FAIL host_read_latency got=%0d exp=1", lat); end
    if (rd !== 32'h6162_6364) begin n_fail++; $display("FAIL host_read_data got=%h exp=61626364", rd); end
    @(negedge clk);
    n_checks++;
    if (host_ack !== 1'b0) begin n_fail++; $display("FAIL host_ack_width got=%b exp=0", host_ack); end
  endtask

  task automatic test_core_read();
    logic [31:0] rd;
    int lat;
    core_active = 1'b0;
    for (int i = 0; i < 20; i++) begin
      host_access(1'b1, i, $urandom, rd, lat);
      @(negedge clk);
    end
    core_active = 1'b1;
    for (int i = 0; i < 20; i++) begin
      core_cycle(1'b0, i, 32'd0, 1'b0, rd);
      exp_q.push_back(rd);
      n_checks++;
      if (mem_read_data !== exp_q[0]) begin
        n_fail++;
        $display("FAIL core_read addr=%0d got=%h exp=%h", i, mem_read_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    core_idle();
  endtask

  task automatic test_capture();
    logic [31:0] rd;
    logic [31:0] h [OUT_WORDS];
    int lat;
    core_active = 1'b1;
    out_base = 16'h0100; model_base = 'h100;
    core_cycle(1'b0, 0, 32'd0, 1'b1, rd);
    core_idle();
    n_checks += 2;
    if (wr_count !== 4'd0)   begin n_fail++; $display("FAIL arm_wr_count got=%0d exp=0", wr_count); end
    if (hash_valid !== 1'b0) begin n_fail++; $display("FAIL arm_hash_valid got=%b exp=0", hash_valid); end
    for (int i = 0; i < OUT_WORDS; i++) begin
      h[i] = $urandom;
      core_cycle(1'b1, 'h100 + i, h[i], 1'b0, rd);
      n_checks += 2;
      if (wr_count !== 4'(i + 1)) begin n_fail++; $display("FAIL capture_wr_count step=%0d got=%0d exp=%0d", i, wr_count, i + 1); end
      if (hash_valid !== (i == OUT_WORDS - 1)) begin n_fail++; $display("FAIL capture_hash_valid step=%0d got=%b exp=%b", i, hash_valid, i == OUT_WORDS - 1); end
    end
    core_idle();
    @(negedge clk);
    n_checks++;
    if (hash_valid !== 1'b1) begin n_fail++; $display("FAIL hash_valid_hold got=%b exp=1", hash_valid); end
    core_active = 1'b0;
    for (int i = 0; i < OUT_WORDS; i++) begin
      host_access(1'b0, 'h100 + i, 32'd0, rd, lat);
      n_checks++;
      if (rd !== h[i]) begin n_fail++; $display("FAIL capture_readback idx=%0d got=%h exp=%h", i, rd, h[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_duplicates();
    logic [31:0] rd;
    logic [31:0] d_lo, d_hi;
    int lat;
    d_lo = $urandom; d_hi = $urandom;
    core_active = 1'b1;
    core_cycle(1'b0, 0, 32'd0, 1'b1, rd);
    core_cycle(1'b1, 'h103, $urandom, 1'b0, rd);
    core_cycle(1'b1, 'h103, $urandom, 1'b0, rd);
    core_cycle(1'b1, 'h0FF, d_lo, 1'b0, rd);
    core_cycle(1'b1, 'h108, d_hi, 1'b0, rd);
    core_idle();
    @(negedge clk);
    n_checks += 2;
    if (wr_count !== 4'd1)   begin n_fail++; $display("FAIL dup_wr_count got=%0d exp=1", wr_count); end
    if (hash_valid !== 1'b0) begin n_fail++; $display("FAIL dup_hash_valid got=%b exp=0", hash_valid); end
    core_active = 1'b0;
    host_access(1'b0, 'h0FF, 32'd0, rd, lat);
    n_checks++;
    if (rd !== d_lo) begin n_fail++; $display("FAIL edge_below_window got=%h exp=%h", rd, d_lo); end
    @(negedge clk);
    host_access(1'b0, 'h108, 32'd0, rd, lat);
    n_checks++;
    if (rd !== d_hi) begin n_fail++; $display("FAIL edge_above_window got=%h exp=%h", rd, d_hi); end
    @(negedge clk);
  endtask

  task automatic test_window_wrap();
    logic [31:0] rd;
    core_active = 1'b1;
    out_base = 16'hFFFC; model_base = 'hFFFC;
    core_cycle(1'b0, 0, 32'd0, 1'b1, rd);
    core_cycle(1'b1, 2, $urandom, 1'b0, rd);
    core_idle();
    @(negedge clk);
    n_checks++;
    if (wr_count !== 4'd0) begin n_fail++; $display("FAIL window_no_wrap got=%0d exp=0", wr_count); end
    out_base = 16'h0100; model_base = 'h100;
  endtask

  task automatic test_host_blocked();
    int acks = 0;
    int lat = 0;
    core_active = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0100; host_wdata = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (host_ack) acks++;
    end
    n_checks++;
    if (acks !== 0) begin n_fail++; $display("FAIL blocked_no_ack got=%0d exp=0", acks); end
    core_active = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!host_ack && lat < 10);
    n_checks += 2;
    if (!host_ack || lat > 2) begin n_fail++; $display("FAIL blocked_release_ack latency=%0d ack=%b exp_latency<=2", lat, host_ack); end
    if (host_rdata !== model_mem['h100]) begin n_fail++; $display("FAIL blocked_read_data got=%h exp=%h", host_rdata, model_mem['h100]); end
    host_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [31:0] w [4];
    int lat;
    core_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      host_access(1'b1, 40 + i, w[i], rd, lat);
      n_checks++;
      if (lat !== ((i == 0) ? 1 : 2)) begin n_fail++; $display("FAIL b2b_latency idx=%0d got=%0d exp=%0d", i, lat, (i == 0) ? 1 : 2); end
    end
    for (int i = 0; i < 4; i++) begin
      host_access(1'b0, 40 + i, 32'd0, rd, lat);
      n_checks++;
      if (rd !== w[i]) begin n_fail++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", i, rd, w[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_oob_arm();
    logic [31:0] rd;
    int lat;
    core_active = 1'b1;
    core_cycle(1'b0, 0, 32'd0, 1'b1, rd);
    core_cycle(1'b0, 5, 32'd0, 1'b0, rd);
    n_checks++;
    if (mem_read_data !== rd) begin n_fail++; $display("FAIL oob_pre_read got=%h exp=%h", mem_read_data, rd); end
    core_cycle(1'b0, 'h400, 32'd0, 1'b0, rd);
    n_checks += 2;
    if (mem_read_data !== OOB_DATA) begin n_fail++; $display("FAIL oob_read_data got=%h exp=%h", mem_read_data, OOB_DATA); end
    if (oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_err_set got=%b exp=1", oob_err); end
    core_cycle(1'b1, 'h400, 32'hDEAD_BEEF, 1'b0, rd);
    core_cycle(1'b0, 0, 32'd0, 1'b1, rd);
    core_idle();
    n_checks++;
    if (oob_err !== 1'b0) begin n_fail++; $display("FAIL oob_err_arm_clear got=%b exp=0", oob_err); end
    core_active = 1'b0;
    host_access(1'b0, 0, 32'd0, rd, lat);
    n_checks++;
    if (rd !== model_mem[0]) begin n_fail++; $display("FAIL oob_write_dropped got=%h exp=%h", rd, model_mem[0]); end
    @(negedge clk);
    host_access(1'b0, 'h7FF, 32'd0, rd, lat);
    n_checks += 2;
    if (rd !== OOB_DATA) begin n_fail++; $display("FAIL host_oob_data got=%h exp=%h", rd, OOB_DATA); end
    if (oob_err !== 1'b1) begin n_fail++; $display("FAIL host_oob_err got=%b exp=1", oob_err); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] rd;
    int base, addr, r;
    bit we, a;
    core_active = 1'b1;
    base = $urandom_range(0, 1016);
    out_base = 16'(base); model_base = base;
    core_cycle(1'b0, 0, 32'd0, 1'b1, rd);
    for (int c = 0; c < 400; c++) begin
      r  = $urandom_range(0, 9);
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 29) == 0);
      if (r < 5)      addr = base + $urandom_range(0, 9);
      else if (r < 9) addr = $urandom_range(0, DEPTH - 1);
      else            addr = DEPTH + $urandom_range(0, 100);
      core_cycle(we, addr, $urandom, a, rd);
      n_checks += 4;
      if (mem_read_data !== rd) begin n_fail++; $display("FAIL rand_read c=%0d addr=%0d got=%h exp=%h", c, addr, mem_read_data, rd); end
      if (wr_count !== 4'(model_count())) begin n_fail++; $display("FAIL rand_wr_count c=%0d got=%0d exp=%0d", c, wr_count, model_count()); end
      if (hash_valid !== model_hv) begin n_fail++; $display("FAIL rand_hash_valid c=%0d got=%b exp=%b", c, hash_valid, model_hv); end
      if (oob_err !== model_oob) begin n_fail++; $display("FAIL rand_oob_err c=%0d got=%b exp=%b", c, oob_err, model_oob); end
    end
    core_idle();
    @(negedge clk);
    out_base = 16'h0100; model_base = 'h100;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat;
    core_active = 1'b1;
    core_cycle(1'b0, 0, 32'd0, 1'b1, rd);
    for (int i = 0; i < 3; i++) core_cycle(1'b1, 'h100 + i, $urandom, 1'b0, rd);
    core_idle();
    core_active = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0101;
    @(negedge clk);
    n_checks += 2;
    if (host_ack !== 1'b1)   begin n_fail++; $display("FAIL pre_reset_ack got=%b exp=1", host_ack); end
    if (wr_count !== 4'd3)   begin n_fail++; $display("FAIL pre_reset_wr_count got=%0d exp=3", wr_count); end
    #2 reset_n = 1'b0;
    #1;
    n_checks += 6;
    if (mem_read_data !== 32'd0) begin n_fail++; $display("FAIL mid_reset_mem_read_data got=%h exp=0", mem_read_data); end
    if (host_rdata !== 32'd0)    begin n_fail++; $display("FAIL mid_reset_host_rdata got=%h exp=0", host_rdata); end
    if (host_ack !== 1'b0)       begin n_fail++; $display("FAIL mid_reset_host_ack got=%b exp=0", host_ack); end
    if (wr_count !== 4'd0)       begin n_fail++; $display("FAIL mid_reset_wr_count got=%0d exp=0", wr_count); end
    if (hash_valid !== 1'b0)     begin n_fail++; $display("FAIL mid_reset_hash_valid got=%b exp=0", hash_valid); end
    if (oob_err !== 1'b0)        begin n_fail++; $display("FAIL mid_reset_oob_err got=%b exp=0", oob_err); end
    host_req = 1'b0;
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (host_ack !== 1'b0) begin n_fail++; $display("FAIL post_reset_no_ack got=%b exp=0", host_ack); end
    host_access(1'b0, 'h101, 32'd0, rd, lat);
    n_checks++;
    if (rd !== model_mem['h101]) begin n_fail++; $display("FAIL ram_survives_reset got=%h exp=%h", rd, model_mem['h101]); end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    mem_we = 1'b0; mem_addr = 16'd0; mem_write_data = 32'd0;
    core_active = 1'b0; host_req = 1'b0; host_we = 1'b0;
    host_addr = 16'd0; host_wdata = 32'd0;
    out_base = 16'h0100; model_base = 'h100; arm = 1'b0;
    model_clear();
    test_reset();
    preload_all();
    test_host_rw();
    test_core_read();
    test_capture();
    test_duplicates();
    test_window_wrap();
    test_host_blocked();
    test_back_to_back();
    test_oob_arm();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
